mem_access_unit: RTL and testbench

- Executes the memory fields of the decoded micro command: MREN/MWEN width codes plus the UNSIGN bit.
- Turns one load or store into a single word-aligned bus transaction with byte strobes.
- Returns sign- or zero-extended load data, or a store completion, to the execute stage.
- Sits between execute/writeback and the data memory port; one transaction outstanding at a time.

---
 rtl/mem_access_unit_if.sv | 43 ++++
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Execute-side request/response and data-memory bus bundle for mem_access_unit.
// master = the access unit's view, slave = the execute stage / memory side.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        mren;
    logic [1:0]        mwen;
    logic              unsign;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  req_valid, mren, mwen, unsign, addr, wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        output req_valid, mren, mwen, unsign, addr, wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one word-aligned bus transaction per micro command, extended load data back.
// Optional macro LSU_TIMEOUT_EN adds a REQ/WAIT watchdog that ends the access with an error.

// Per byte lane: strobe and write byte for the accepted width/offset.
module mau_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0] width,
    input  logic       st,
    input  logic [1:0] off,
    input  logic [7:0] byte_b,
    input  logic [7:0] byte_h,
    input  logic [7:0] byte_w,
    output logic       strb,
    output logic [7:0] wbyte
);
    localparam logic [2:0] L3 = 3'(LANE);
    logic [2:0] o3;

    assign o3 = {1'b0, off};

    always_comb begin
        strb  = 1'b0;
        wbyte = 8'h00;
        case (width)
            2'b01: begin
                strb  = (o3 == L3);
                wbyte = byte_b;
            end
            2'b10: begin
                strb  = (o3 == L3) || ((o3 + 3'd1) == L3);
                wbyte = byte_h;
            end
            2'b11: begin
                strb  = 1'b1;
                wbyte = byte_w;
            end
            default: ;
        endcase
        if (!st) wbyte = 8'h00;
    end
endmodule

module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_access_unit_if.master io
);
    localparam int NUM_LANES = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t state, state_nx;

    logic [1:0]                  mren_q, mwen_q, off_q;
    logic                        unsign_q;
    logic [ADDR_W-1:0]           baddr_q;
    logic [NUM_LANES-1:0]        wstrb_d, wstrb_q;
    logic [NUM_LANES-1:0][7:0]   wdata_d, wdata_q;
    logic [DATA_W-1:0]           rdata_q, rdata_nx, lane_w, ld_ext;
    logic                        err_q, err_nx;
    logic [1:0]                  width;
    logic                        accept, illegal, misalign, tmo;

    assign accept   = (state == IDLE) && io.req_valid;
    assign width    = (io.mren != 2'b00) ? io.mren : io.mwen;
    assign illegal  = (io.mren != 2'b00) && (io.mwen != 2'b00);
    assign misalign = ((width == 2'b10) && io.addr[0]) ||
                      ((width == 2'b11) && (io.addr[1:0] != 2'b00));

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mau_lane #(.LANE(i)) u_lane (
            .width  (width),
            .st     (io.mwen != 2'b00),
            .off    (io.addr[1:0]),
            .byte_b (io.wdata[7:0]),
            .byte_h (io.wdata[8*(i%2) +: 8]),
            .byte_w (io.wdata[8*i +: 8]),
            .strb   (wstrb_d[i]),
            .wbyte  (wdata_d[i])
        );
    end

    // Shift the addressed lane down to bit 0, then extend to the field width.
    assign lane_w = io.bus_rdata >> {off_q, 3'b000};

    always_comb begin
        case (mren_q)
            2'b01:   ld_ext = unsign_q ? {{(DATA_W-8){1'b0}}, lane_w[7:0]}
                                       : {{(DATA_W-8){lane_w[7]}}, lane_w[7:0]};
            2'b10:   ld_ext = unsign_q ? {{(DATA_W-16){1'b0}}, lane_w[15:0]}
                                       : {{(DATA_W-16){lane_w[15]}}, lane_w[15:0]};
            default: ld_ext = lane_w;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Cleared on every state change, so each entry into REQ or WAIT starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n)
            tmo_cnt <= 8'd0;
        else if (state_nx != state)
            tmo_cnt <= 8'd0;
        else if ((state == REQ) || (state == WAIT))
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    assign tmo = ((state == REQ) || (state == WAIT)) && (tmo_cnt == 8'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
    assign tmo        = 1'b0;
`endif

    // Response payload is only non-zero on the edge that enters RESP.
    always_comb begin
        state_nx = state;
        rdata_nx = '0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (io.req_valid) begin
                    if ((io.mren == 2'b00) && (io.mwen == 2'b00)) begin
                        state_nx = RESP;
                    end else if (illegal || misalign) begin
                        state_nx = RESP;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                if (io.bus_ready) begin
                    state_nx = (mwen_q != 2'b00) ? RESP : WAIT;
                end else if (tmo) begin
                    state_nx = RESP;
                    err_nx   = 1'b1;
                end
            end
            WAIT: begin
                if (io.bus_rvalid) begin
                    state_nx = RESP;
                    rdata_nx = ld_ext;
                end else if (tmo) begin
                    state_nx = RESP;
                    err_nx   = 1'b1;
                end
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mren_q   <= 2'b00;
            mwen_q   <= 2'b00;
            off_q    <= 2'b00;
            unsign_q <= 1'b0;
            baddr_q  <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            rdata_q <= rdata_nx;
            err_q   <= err_nx;
            if (accept) begin
                mren_q   <= io.mren;
                mwen_q   <= io.mwen;
                off_q    <= io.addr[1:0];
                unsign_q <= io.unsign;
                baddr_q  <= {io.addr[ADDR_W-1:2], 2'b00};
                wstrb_q  <= wstrb_d;
                wdata_q  <= wdata_d;
            end
        end
    end

    assign io.req_ready  = (state == IDLE);
    assign io.resp_valid = (state == RESP);
    assign io.resp_rdata = rdata_q;
    assign io.resp_err   = err_q;

    assign io.bus_valid  = (state == REQ);
    assign io.bus_we     = io.bus_valid && (mwen_q != 2'b00);
    assign io.bus_addr   = io.bus_valid ? baddr_q : '0;
    assign io.bus_wstrb  = io.bus_valid ? wstrb_q : '0;
    assign io.bus_wdata  = io.bus_valid ? wdata_q : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: an arithmetic reference model plus a per-cycle compare process.
module tb_mem_access_unit;
    localparam int TMO = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) io ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.master)
    );

    int checks = 0;
    int errors = 0;

    logic        in_txn = 1'b0;
    logic        exp_bus, exp_we, exp_err;
    logic [31:0] exp_baddr, exp_wdata, exp_rdata;
    logic [3:0]  exp_strb;
    int          exp_lat;
    logic [31:0] got_rdata, last_baddr, last_wdata;
    logic        got_err, last_we;
    logic [3:0]  last_strb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte count and offset arithmetic, no state machine.
    function automatic void model(input logic [1:0] mr, input logic [1:0] mw, input logic u,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rd, input int d, input int rv);
        int nb, off;
        logic [1:0] w;
        longint v, span;
        w = (mr != 2'b00) ? mr : mw;
        nb = (w == 2'b01) ? 1 : (w == 2'b10) ? 2 : 4;
        off = int'(a[1:0]);
        exp_baddr = a & 32'hFFFF_FFFC;
        exp_we = (mw != 2'b00);
        exp_rdata = 0; exp_err = 0; exp_strb = 0; exp_wdata = 0;
        if (mr == 2'b00 && mw == 2'b00) begin
            exp_bus = 0; exp_lat = 1;
        end else if ((mr != 2'b00 && mw != 2'b00) || (off % nb) != 0) begin
            exp_bus = 0; exp_err = 1; exp_lat = 1;
        end else begin
            exp_bus = 1;
            for (int i = 0; i < 4; i++) begin
                exp_strb[i] = (i >= off) && (i < off + nb);
                exp_wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
            end
            if (exp_we) exp_lat = 2 + d;
            else begin
                span = longint'(1) << (8*nb);
                v = longint'(rd >> (8*off)) % span;
                if (!u && v >= span/2) v = v - span;
                exp_rdata = v[31:0];
                exp_lat = 3 + d + rv;
`ifdef LSU_TIMEOUT_EN
                if (rv >= TMO) begin
                    exp_rdata = 0; exp_err = 1; exp_lat = 2 + d + TMO;
                end
`endif
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (!in_txn) begin
                chk("idle_req_ready", io.req_ready, 1);
                chk("idle_bus_valid", io.bus_valid, 0);
                chk("idle_resp_valid", io.resp_valid, 0);
                chk("idle_resp_rdata", io.resp_rdata, 0);
            end else begin
                chk("busy_req_ready", io.req_ready, 0);
                if (io.bus_valid) begin
                    chk("bus_valid_allowed", io.bus_valid, exp_bus);
                    chk("bus_addr", io.bus_addr, exp_baddr);
                    chk("bus_we", io.bus_we, exp_we);
                    if (exp_we) begin
                        chk("bus_wstrb", io.bus_wstrb, exp_strb);
                        chk("bus_wdata", io.bus_wdata, exp_wdata);
                    end
                    last_baddr = io.bus_addr; last_we = io.bus_we;
                    last_strb = io.bus_wstrb; last_wdata = io.bus_wdata;
                end
                if (io.resp_valid) begin
                    chk("resp_rdata", io.resp_rdata, exp_rdata);
                    chk("resp_err", io.resp_err, exp_err);
                end else begin
                    chk("resp_rdata_quiet", io.resp_rdata, 0);
                    chk("resp_err_quiet", io.resp_err, 0);
                end
            end
        end
    end

    task automatic txn(input string nm, input logic [1:0] mr, input logic [1:0] mw, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int d, input int rv);
        bit ld, got;
        int lat;
        model(mr, mw, u, a, wd, rd, d, rv);
        ld = (mr != 2'b00) && (mw == 2'b00);
        io.mren = mr; io.mwen = mw; io.unsign = u; io.addr = a; io.wdata = wd;
        io.bus_rdata = rd; io.bus_ready = (d == 0); io.bus_rvalid = 1'b0;
        io.req_valid = 1'b1;
        @(posedge clk); #1;
        io.req_valid = 1'b0;
        io.mren = 2'b11; io.mwen = 2'b11; io.addr = 32'hFFFF_FFFF;
        in_txn = 1'b1;
        got = 0; lat = -1;
        for (int c = 1; c <= 600 && !got; c++) begin
            io.bus_ready  = (c > d);
            io.bus_rvalid = ld ? (c >= 2 + d + rv) : 1'b1;
            @(negedge clk);
            if (io.resp_valid) begin
                got = 1; lat = c; got_rdata = io.resp_rdata; got_err = io.resp_err;
            end
            @(posedge clk); #1;
        end
        in_txn = 1'b0;
        io.bus_ready = 1'b0; io.bus_rvalid = 1'b0;
        chk({nm, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        io.req_valid = 0; io.mren = 0; io.mwen = 0; io.unsign = 0; io.addr = 0; io.wdata = 0;
        io.bus_ready = 0; io.bus_rvalid = 0; io.bus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", io.req_ready, 1);
        chk("rst_bus_valid", io.bus_valid, 0);
        chk("rst_bus_we", io.bus_we, 0);
        chk("rst_bus_wstrb", io.bus_wstrb, 0);
        chk("rst_resp_valid", io.resp_valid, 0);
        chk("rst_resp_err", io.resp_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn("lb_signed", 2'b01, 2'b00, 0, 32'h8000_0003, 32'h0, 32'h8100_0000, 0, 0);
        chk("lb_lit_rdata", got_rdata, 32'hFFFF_FF81);
        chk("lb_lit_addr", last_baddr, 32'h8000_0000);
        chk("lb_lit_we", last_we, 0);
        txn("lhu", 2'b10, 2'b00, 1, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 0, 0);
        chk("lhu_lit_rdata", got_rdata, 32'h0000_BEEF);
        txn("sb", 2'b00, 2'b01, 0, 32'h8000_0001, 32'h1234_56AB, 32'h5555_5555, 0, 0);
        chk("sb_lit_strb", last_strb, 4'b0010);
        chk("sb_lit_wdata", last_wdata, 32'hABAB_ABAB);
        chk("sb_lit_we", last_we, 1);
        txn("sw_misaligned", 2'b00, 2'b11, 0, 32'h8000_0002, 32'h1111_2222, 32'h0, 0, 0);
        chk("sw_mis_lit_err", got_err, 1);
        txn("sw_backpressure", 2'b00, 2'b11, 0, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 5, 0);
        chk("sw_bp_lit_wdata", last_wdata, 32'hDEAD_BEEF);
        txn("lw_slow", 2'b11, 2'b00, 0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 2, 2);
        chk("lw_lit_rdata", got_rdata, 32'hCAFE_F00D);
        txn("lh_signed", 2'b10, 2'b00, 0, 32'h0000_0002, 32'h0, 32'h8001_0000, 1, 0);
        chk("lh_lit_rdata", got_rdata, 32'hFFFF_8001);
        txn("lbu", 2'b01, 2'b00, 1, 32'h0000_0001, 32'h0, 32'h0000_F000, 0, 1);
        txn("sh_upper", 2'b00, 2'b10, 0, 32'h0000_0006, 32'h0000_1357, 32'h0, 0, 0);
        chk("sh_lit_strb", last_strb, 4'b1100);
        txn("illegal", 2'b11, 2'b01, 0, 32'h0000_0000, 32'h0, 32'h0, 0, 0);
        txn("noop", 2'b00, 2'b00, 0, 32'h0000_0040, 32'h0, 32'hFFFF_FFFF, 0, 0);
        chk("noop_lit_err", got_err, 0);
        txn("lh_misaligned", 2'b10, 2'b00, 0, 32'h0000_0003, 32'h0, 32'h0, 0, 0);
        txn("lb_positive", 2'b01, 2'b00, 0, 32'h0000_0000, 32'h0, 32'hFFFF_FF7F, 0, 0);
        chk("lb_pos_lit_rdata", got_rdata, 32'h0000_007F);

        // Reset while the load sits in WAIT; a late rvalid must not produce a response.
        model(2'b11, 2'b00, 0, 32'h0000_0020, 32'h0, 32'h0, 0, 0);
        io.mren = 2'b11; io.mwen = 2'b00; io.addr = 32'h0000_0020; io.bus_ready = 1'b1;
        io.req_valid = 1'b1;
        @(posedge clk); #1;
        io.req_valid = 1'b0; in_txn = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_txn = 1'b0; io.bus_ready = 1'b0;
        io.bus_rvalid = 1'b1; io.bus_rdata = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1 io.bus_rvalid = 1'b0;
        @(posedge clk); #1;

        txn("post_reset_lw", 2'b11, 2'b00, 0, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 0, 0);
`ifdef LSU_TIMEOUT_EN
        txn("lw_timeout", 2'b11, 2'b00, 0, 32'h0000_0200, 32'h0, 32'h7777_7777, 0, 1000);
        chk("timeout_lit_err", got_err, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
